bit_frame_stream_gen: RTL and testbench
=======================================

BIT_FRAME_STREAM_GEN -- requirements
Module: bit_frame_stream_gen

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 11'd640: active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 11'd480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 11'd160: blanking cycles per line.
REQ-004 SHALL have parameter V_BLANK, default 11'd45: blanking lines per frame.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  level/pulse; sampled in IDLE to begin streaming.
REQ-008 SHALL have port stop  in  1  request to finish the current frame and return to IDLE.
REQ-009 SHALL have port pattern_sel  in  2  pixel source: 0 checkerboard, 1 vertical bars, 2 external, 3 all-ones.
REQ-010 SHALL have port ext_bit  in  1  external pixel, valid in any cycle ext_req is high.
REQ-011 SHALL have port ext_req  out  1  external pixel request, high one cycle before each active href cycle.
REQ-012 SHALL have port out_frame_vsync  out  1  frame-valid, high across all active lines of a frame.
REQ-013 SHALL have port out_frame_href  out  1  line-valid, high for IMG_HDISP consecutive cycles per active line.
REQ-014 SHALL have port out_img_Bit  out  1  pixel bit, meaningful only while out_frame_href is high.
REQ-015 SHALL have port busy  out  1  high while in RUN state.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the last cycle of each frame.

Function
REQ-017 SHALL implement states IDLE and RUN; IDLE->RUN when start=1 in IDLE; start in RUN ignored.
REQ-018 SHALL run counters h_cnt (0..HTOTAL-1, HTOTAL=IMG_HDISP+H_BLANK) and v_cnt (0..VTOTAL-1, VTOTAL=IMG_VDISP+V_BLANK), both zero on entering RUN; h_cnt wraps to 0 and increments v_cnt at HTOTAL-1; v_cnt wraps to 0 at VTOTAL-1.
REQ-019 SHALL form internal line_act = RUN & (h_cnt<IMG_HDISP) & (v_cnt<IMG_VDISP) and frame_act = RUN & (v_cnt<IMG_VDISP).
REQ-020 SHALL drive ext_req = line_act combinationally (one cycle ahead of out_frame_href).
REQ-021 SHALL register out_frame_href <= line_act and out_frame_vsync <= frame_act (one-cycle latency from counters).
REQ-022 SHALL register out_img_Bit <= line_act ? pixel : 0, where pixel = h_cnt[3]^v_cnt[3] (sel 0), h_cnt[4] (sel 1), ext_bit (sel 2), 1 (sel 3).
REQ-023 SHALL latch pattern_sel at h_cnt=0, v_cnt=0 of each frame; mid-frame changes take effect next frame.
REQ-024 SHALL set a stop_pending flag when stop=1 in RUN; at h_cnt=HTOTAL-1, v_cnt=VTOTAL-1 with stop_pending (or stop) set, SHALL go to IDLE and clear the flag; otherwise continue the next frame immediately.
REQ-025 SHALL, with start and stop both high in IDLE, enter RUN, set stop_pending and stream exactly one frame.
REQ-026 SHALL pulse frame_done for one cycle in the cycle after h_cnt=HTOTAL-1, v_cnt=VTOTAL-1, whether or not streaming stops.
REQ-027 SHALL hold busy = (state==RUN), registered with the state.
REQ-028 SHALL first assert out_frame_href and out_frame_vsync exactly 2 cycles after the cycle start is sampled high in IDLE.

Reset
REQ-029 SHALL, on rst_n low (any time, including mid-frame), immediately force state IDLE, counters 0, stop_pending 0, pattern latch 0, and outputs out_frame_vsync, out_frame_href, out_img_Bit, busy, frame_done to 0; ext_req follows to 0.
REQ-030 SHALL require start after reset release to resume; no partial frame is completed.

Verification (IMG_HDISP=4, IMG_VDISP=3, H_BLANK=2, V_BLANK=2: 30 cycles/frame)
REQ-031 SHALL check: start pulse at cycle 0, sel=3 -> href high cycles 2-5, 8-11, 14-17, vsync high cycles 2-19, out_img_Bit=1 during href, frame_done at cycle 31, next href at cycle 32.
REQ-032 SHALL check: sel=2, ext_bit driven 1,0,1,1 on successive ext_req cycles -> out_img_Bit 1,0,1,1 one cycle later with href high.
REQ-033 SHALL check: stop pulsed at cycle 10 of frame 1 -> frame 1 completes, frame_done pulses once, busy falls with it, no further href.
REQ-034 SHALL check: start and stop high together in IDLE -> exactly one frame (3 lines x 4 pixels), then IDLE.
REQ-035 SHALL check: rst_n low at cycle 9 (mid-line) -> all outputs 0 within that cycle, no href after release until new start.
REQ-036 SHALL check: pattern_sel 3->0 changed at cycle 8 -> frame 1 stays all-ones; frame 2 all zeros (h_cnt<8, v_cnt<8).

Source files
------------

// File: rtl/bit_frame_stream_gen.sv
// Free-running 1-bit video frame generator: vsync/href timing from h/v counters
// plus a selectable pixel pattern, with start/stop control at frame boundaries.
module bit_frame_stream_gen #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_BLANK   = 11'd45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] pattern_sel,
  input  logic       ext_bit,
  output logic       ext_req,
  output logic       out_frame_vsync,
  output logic       out_frame_href,
  output logic       out_img_Bit,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(IMG_VDISP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_HDISP) + CNT_W'(H_BLANK) - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(IMG_VDISP) + CNT_W'(V_BLANK) - CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             stop_pending;
  logic             stop_pending_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [1:0]       pat_q;
  logic [1:0]       pat_eff;
  logic             running;
  logic             frame_first;
  logic             frame_last;
  logic             line_act;
  logic             frame_act;
  logic             pixel;

  assign running     = (state == RUN);
  assign frame_first = running && (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = running && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign line_act    = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_act   = running && (v_cnt < V_ACT);
  assign ext_req     = line_act;

  // The first pixel of a frame sees the new selection before the latch captures it
  assign pat_eff = frame_first ? pattern_sel : pat_q;

  // Next-state and stop bookkeeping
  always_comb begin
    state_nxt        = state;
    stop_pending_nxt = stop_pending;
    case (state)
      IDLE: begin
        stop_pending_nxt = 1'b0;
        if (start) begin
          state_nxt        = RUN;
          stop_pending_nxt = stop;
        end
      end
      RUN: begin
        if (stop) begin
          stop_pending_nxt = 1'b1;
        end
        if (frame_last && (stop_pending || stop)) begin
          state_nxt        = IDLE;
          stop_pending_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt        = IDLE;
        stop_pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      stop_pending <= stop_pending_nxt;
    end
  end

  // Raster counters; held at zero outside RUN so each run starts at pixel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 2'd0;
    end else if (frame_first) begin
      pat_q <= pattern_sel;
    end
  end

  // Pixel source select
  always_comb begin
    pixel = 1'b0;
    case (pat_eff)
      2'd0: pixel = h_cnt[3] ^ v_cnt[3];
      2'd1: pixel = h_cnt[4];
      2'd2: pixel = ext_bit;
      2'd3: pixel = 1'b1;
      default: pixel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_frame_href  <= 1'b0;
      out_frame_vsync <= 1'b0;
      out_img_Bit     <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      out_frame_href  <= line_act;
      out_frame_vsync <= frame_act;
      out_img_Bit     <= line_act & pixel;
      busy            <= (state_nxt == RUN);
      frame_done      <= frame_last;
    end
  end

endmodule

// File: tb/tb_bit_frame_stream_gen.sv
// Directed bench for bit_frame_stream_gen on a 4x3 image with 2/2 blanking
// (6 x 5 = 30 cycles per frame).
module tb_bit_frame_stream_gen;

  localparam int HT = 6;
  localparam int HD = 4;
  localparam int VD = 3;
  localparam int FT = 30;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] pattern_sel;
  logic       ext_bit;
  logic       ext_req;
  logic       out_frame_vsync;
  logic       out_frame_href;
  logic       out_img_Bit;
  logic       busy;
  logic       frame_done;

  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [11:0] ext_seq;

  bit_frame_stream_gen #(
    .IMG_HDISP(11'd4),
    .IMG_VDISP(11'd3),
    .H_BLANK  (11'd2),
    .V_BLANK  (11'd2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .pattern_sel    (pattern_sel),
    .ext_bit        (ext_bit),
    .ext_req        (ext_req),
    .out_frame_vsync(out_frame_vsync),
    .out_frame_href (out_frame_href),
    .out_img_Bit    (out_img_Bit),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-local index -> position inside the active window
  function automatic bit in_line(input int idx);
    return ((idx % HT) < HD) && ((idx / HT) < VD);
  endfunction

  function automatic bit in_frame(input int idx);
    return (idx / HT) < VD;
  endfunction

  // Start in cycle 0, then check every output each cycle. Counter index at
  // cycle k is k-1 while streaming; streaming ends after counter index last_idx.
  task automatic run_seq(input int ncyc, input int stop_cyc, input int last_idx,
                         input logic [1:0] sel0, input int chg_cyc, input logic [1:0] sel1,
                         input int ones_lim, input bit ext_mode);
    int   cidx;
    int   k;
    bit   act_prev;
    bit   exp_href;
    bit   exp_busy;
    bit   exp_ereq;
    bit   exp_img;
    logic prev_bit;
    logic cur_bit;
    pattern_sel = sel0;
    start       = 1'b1;
    stop        = (stop_cyc == 0);
    ext_bit     = 1'b0;
    prev_bit    = 1'b0;
    k           = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      cyc      = c;
      cidx     = c - 2;
      act_prev = (cidx >= 0) && (cidx <= last_idx);
      exp_href = act_prev && in_line(cidx % FT);
      exp_busy = (c - 1) <= last_idx;
      exp_ereq = exp_busy && in_line((c - 1) % FT);
      exp_img  = exp_href && (ext_mode ? prev_bit : (cidx < ones_lim));
      check("href",       out_frame_href,  exp_href);
      check("vsync",      out_frame_vsync, act_prev && in_frame(cidx % FT));
      check("frame_done", frame_done,      act_prev && ((cidx % FT) == FT - 1));
      check("busy",       busy,            exp_busy);
      check("ext_req",    ext_req,         exp_ereq);
      check("img_bit",    out_img_Bit,     exp_img);
      start = 1'b0;
      stop  = (c == stop_cyc);
      if (c == chg_cyc) pattern_sel = sel1;
      if (exp_ereq) begin
        cur_bit = ext_seq[11 - (k % 12)];
        k++;
      end else begin
        cur_bit = 1'($urandom);
      end
      ext_bit  = cur_bit;
      prev_bit = cur_bit;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_href"},  out_frame_href,  1'b0);
    check({tag, "_vsync"}, out_frame_vsync, 1'b0);
    check({tag, "_img"},   out_img_Bit,     1'b0);
    check({tag, "_busy"},  busy,            1'b0);
    check({tag, "_done"},  frame_done,      1'b0);
    check({tag, "_ereq"},  ext_req,         1'b0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    ext_seq     = 12'b1011_0110_0101;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    pattern_sel = 2'd0;
    ext_bit     = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("idle");

    // All-ones, two frames back to back, stop in the second frame
    run_seq(70, 40, 59, 2'd3, -1, 2'd3, 1000, 1'b0);
    // External pixels, single frame (start+stop together)
    run_seq(36, 0, 29, 2'd2, -1, 2'd2, 0, 1'b1);
    // Pattern change mid-frame only takes effect on the next frame
    run_seq(70, 40, 59, 2'd3, 8, 2'd0, FT, 1'b0);
    // start+stop together in IDLE -> exactly one frame
    run_seq(36, 0, 29, 2'd3, -1, 2'd3, 1000, 1'b0);

    // Reset mid-line
    pattern_sel = 2'd3;
    start       = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      cyc   = c;
      start = 1'b0;
    end
    check("pre_rst_href",  out_frame_href,  1'b1);
    check("pre_rst_vsync", out_frame_vsync, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      cyc = 100 + c;
      check("post_rst_href",  out_frame_href,  1'b0);
      check("post_rst_vsync", out_frame_vsync, 1'b0);
      check("post_rst_busy",  busy,            1'b0);
      check("post_rst_ereq",  ext_req,         1'b0);
    end
    // A fresh start resumes from pixel 0
    run_seq(36, 0, 29, 2'd3, -1, 2'd3, 1000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
